tmip_corr_engine: RTL and testbench
===================================

# tmip_corr_engine

Parametrised cross-correlation engine for the TMIP image path. It loads one grayscale square image (4×4, 8×8 or 16×16, capped at `MAX_DIM`) and a 3×3 template, then waits for a trigger. On each trigger it computes the zero-padded cross-correlation at every pixel and streams each result MSB-first on a single bit. It generalises the fixed-size correlation action of the TMIP core: pixel width and maximum dimension are parameters, one load serves repeated triggers, and a compile-time horizontal-flip mode is available.

## Interface
- `PIX_W`, 8, pixel and template width (unsigned)
- `MAX_DIM`, 16, maximum image side; one of 4, 8, 16
- `OUT_W`, 2*PIX_W+4, result width; holds 9·(2^PIX_W−1)²
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  load strobe; pixels in raster order
- `image`  in  PIX_W  pixel, valid while `in_valid`=1
- `template`  in  PIX_W  template tap, valid in the first 9 `in_valid` cycles, row-major
- `image_size`  in  2  sampled on the first `in_valid` cycle: 0→4, 1→8, 2/3→16, then clamped to `MAX_DIM`
- `in_valid2`  in  1  one-cycle compute trigger
- `flip`  in  1  sampled with `in_valid2`; horizontal mirror (see Configuration)
- `busy`  out  1  high in LOAD, CALC, OUT
- `out_valid`  out  1  serial data qualifier
- `out_value`  out  1  serial result bit, MSB first

## Operation
- FSM: IDLE → LOAD → WAIT → CALC → OUT → WAIT.
- **IDLE**
  - `in_valid`=1 → LOAD. This cycle's pixel, tap and size are captured.
  - `in_valid2` is ignored while no image has been loaded.
- **LOAD**
  - Pixel counter runs 0..dim²−1; template counter runs 0..8.
  - After the last pixel → WAIT.
  - If `in_valid` drops early, the unwritten pixels and taps are zero, and the FSM goes to WAIT on the first low cycle.
  - Extra `in_valid` cycles beyond dim² are ignored.
- **WAIT**
  - `in_valid2`=1 → CALC. `flip` is latched in the same cycle.
  - `in_valid`=1 → LOAD, a fresh load that replaces the image and template.
  - Stored data persists across any number of triggers.
- **CALC**
  - For output position (r,c) in raster order, 9 MAC cycles, one tap per cycle, taps (i,j) in row-major order.
  - acc += t[i][j]·p[r+i−1][c+j−1].
  - Out-of-range coordinates read 0.
  - Unsigned arithmetic, accumulator `OUT_W` bits, no overflow possible.
- **OUT**
  - Finished result is loaded into a shift register and shifted out MSB-first over `OUT_W` cycles.
  - The MAC for the next position runs in parallel (9 < `OUT_W`), so results are back-to-back with no gap.
  - After the last bit of position dim²−1 → WAIT.
- `in_valid`/`in_valid2` are ignored during CALC and OUT.
- Reset in any state:
  - FSM → IDLE, "image loaded" flag cleared, all counters cleared.
  - Outputs go to 0 on the next edge.
  - Any in-progress stream is truncated.

## Timing
- Reset values: `busy`=0, `out_valid`=0, `out_value`=0.
- Outputs are registered.
- `in_valid2` at cycle T:
  - MAC runs in cycles T+1..T+9.
  - `out_valid`=1 and the MSB of result (0,0) appear at T+10.
  - `out_valid` stays high for exactly dim²·`OUT_W` consecutive cycles, then drops to 0 with `out_value`=0.
- `busy` rises the cycle after the first `in_valid` or the `in_valid2`, and falls with `out_valid`.
- LOAD→WAIT occurs the cycle after the last pixel. `in_valid2` is accepted in that next cycle.
- `out_value` is 0 whenever `out_valid`=0.

## Configuration
- Macro: `TMIP_CORR_FLIP_EN`.
- Defined:
  - Latched `flip`=1 mirrors the image horizontally before correlation: column c reads column dim−1−c.
  - The template is not mirrored. Zero padding is applied after the mirror.
- Undefined:
  - `flip` is unconnected internally. Results are always unmirrored.
  - The port remains for pin compatibility.

## Test plan
- 4×4 image, all pixels 1, all taps 1, trigger: 16 results of 20 bits.
  - Corners = 4, edges = 6, interior = 9.
  - (0,0) bits = 0x00004. `out_valid` high for 320 cycles starting at T+10.
- 8×8 image with p=r·8+c and template with only the centre tap = 1: the 64 results equal the pixel values in raster order.
- 16×16 image, all 255, all taps 255: interior = 585225 (0x8EE09), corner = 260100 (0x3F804), with no overflow.
- With `TMIP_CORR_FLIP_EN`, 4×4 ramp p=c, centre tap 1, `flip`=1:
  - Row outputs are 3,2,1,0.
  - A second trigger with `flip`=0 on the same load gives 0,1,2,3.
- `in_valid2` before any load → no `busy` and no `out_valid`.
- `rst` asserted mid-OUT → next cycle all outputs 0.
- A subsequent `in_valid2` without a reload is ignored.

Source files
------------

// File: rtl/tmip_corr_engine_if.sv
// Load/trigger/serial-result bundle for tmip_corr_engine.
// The master drives the image load and the trigger; the slave returns busy and the serial result.
interface tmip_corr_engine_if #(
  parameter int PIX_W = 8
);
  logic             in_valid;
  logic [PIX_W-1:0] image;
  logic [PIX_W-1:0] template;
  logic [1:0]       image_size;
  logic             in_valid2;
  logic             flip;
  logic             busy;
  logic             out_valid;
  logic             out_value;

  modport master (
    output in_valid, image, template, image_size, in_valid2, flip,
    input  busy, out_valid, out_value
  );

  modport slave (
    input  in_valid, image, template, image_size, in_valid2, flip,
    output busy, out_valid, out_value
  );
endinterface

// File: rtl/tmip_corr_engine.sv
// 3x3 zero-padded cross-correlation over a loaded square image, each result streamed MSB-first.
// Optional horizontal image mirror when TMIP_CORR_FLIP_EN is defined.
//   state  | meaning
//   S_IDLE | nothing loaded, trigger ignored
//   S_LOAD | capturing pixels/taps in raster order
//   S_WAIT | image held, waiting for trigger or reload
//   S_CALC | MAC of the first position, no output yet
//   S_OUT  | shifting a result out while the next position accumulates
module tmip_corr_engine #(
  parameter int PIX_W   = 8,
  parameter int MAX_DIM = 16,
  parameter int OUT_W   = 2*PIX_W+4
) (
  input  logic                clk,
  input  logic                rst,
  tmip_corr_engine_if.slave   bus
);
  localparam int RW   = $clog2(MAX_DIM);
  localparam int AW   = 2*RW;
  localparam int NPIX = MAX_DIM*MAX_DIM;
  localparam int BW   = $clog2(OUT_W+1);
  localparam logic [2:0]    RW3      = 3'(RW);
  localparam logic [BW-1:0] BIT_LAST = BW'(OUT_W);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [AW-1:0] FULL     = '1;
  localparam logic [AW-1:0] AW_ONE   = AW'(1);
  localparam logic [RW:0]   D_ONE    = (RW+1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CALC, S_OUT} state_t;

  state_t            state;
  logic [2:0]        dim_log;
  logic [AW-1:0]     pix_cnt;
  logic              iv_hold;
  logic [RW-1:0]     r_idx, c_idx;
  logic [3:0]        k;
  logic [1:0]        ti, tj;
  logic [OUT_W-1:0]  acc, shreg;
  logic [BW-1:0]     bit_cnt;
  logic              mac_done, last_word;
  logic              busy_q, out_valid_q, out_value_q;
  logic              flip_q;

  logic [PIX_W-1:0]  pix [NPIX];
  logic [PIX_W-1:0]  tap [9];

  logic [2:0]        dl_nxt;
  logic [RW:0]       dim, dim_m1;
  logic [AW-1:0]     pix_last;
  logic              start_load, load_wr, start_calc;
  logic [RW:0]       rr_p, cc_p, row_m, col_m;
  logic              row_ok, col_ok;
  logic [AW-1:0]     rd_idx;
  logic [PIX_W-1:0]  rd_pix;
  logic [2*PIX_W-1:0] prod;
  logic [OUT_W-1:0]  sum, word_in;
  logic [1:0]        ti_nx, tj_nx;
  logic [RW-1:0]     r_nx, c_nx;
  logic              last_pos, load_word;

  always_comb begin
    unique case (bus.image_size)
      2'd0:    dl_nxt = 3'd2;
      2'd1:    dl_nxt = 3'd3;
      default: dl_nxt = 3'd4;
    endcase
    if (dl_nxt > RW3) dl_nxt = RW3;
  end

  assign dim      = D_ONE << dim_log;
  assign dim_m1   = dim - D_ONE;
  assign pix_last = FULL >> {RW3 - dim_log, 1'b0};

  assign start_calc = (state == S_WAIT) && bus.in_valid2;
  assign start_load = !rst && bus.in_valid &&
                      ((state == S_IDLE) || ((state == S_WAIT) && !iv_hold && !bus.in_valid2));
  assign load_wr    = !rst && (state == S_LOAD) && bus.in_valid;

  // Coordinates are kept offset by +1 so the padding test stays unsigned.
  assign rr_p   = {1'b0, r_idx} + {{(RW-1){1'b0}}, ti};
  assign cc_p   = {1'b0, c_idx} + {{(RW-1){1'b0}}, tj};
  assign row_ok = (rr_p != '0) && (rr_p <= dim);
  assign col_ok = (cc_p != '0) && (cc_p <= dim);
  assign row_m  = rr_p - D_ONE;
  assign col_m  = flip_q ? (dim - cc_p) : (cc_p - D_ONE);
  assign rd_idx = (AW'(row_m) << dim_log) | AW'(col_m);
  assign rd_pix = (row_ok && col_ok) ? pix[rd_idx] : '0;
  assign prod   = {{PIX_W{1'b0}}, rd_pix} * {{PIX_W{1'b0}}, tap[k]};
  assign sum    = acc + OUT_W'(prod);

  always_comb begin
    ti_nx = ti;
    tj_nx = tj + 2'd1;
    if (tj == 2'd2) begin
      tj_nx = 2'd0;
      ti_nx = ti + 2'd1;
    end
    r_nx = r_idx;
    c_nx = c_idx + RW'(1);
    if ({1'b0, c_idx} == dim_m1) begin
      c_nx = '0;
      r_nx = r_idx + RW'(1);
    end
  end

  assign last_pos  = ({1'b0, r_idx} == dim_m1) && ({1'b0, c_idx} == dim_m1);
  assign load_word = ((state == S_CALC) && (k == 4'd8)) ||
                     ((state == S_OUT) && (bit_cnt == BIT_LAST) && !last_word);
  assign word_in   = (state == S_CALC) ? sum : acc;

`ifdef TMIP_CORR_FLIP_EN
  always_ff @(posedge clk) begin
    if (rst)             flip_q <= 1'b0;
    else if (start_calc) flip_q <= bus.flip;
  end
`else
  assign flip_q = 1'b0;
`endif

  // A fresh load zeroes everything first so a short load leaves the rest at 0.
  always_ff @(posedge clk) begin
    if (start_load) begin
      for (int i = 0; i < NPIX; i++) pix[i] <= '0;
      for (int i = 0; i < 9; i++)    tap[i] <= '0;
      pix[0] <= bus.image;
      tap[0] <= bus.template;
    end else if (load_wr) begin
      pix[pix_cnt] <= bus.image;
      if (pix_cnt < AW'(9)) tap[pix_cnt[3:0]] <= bus.template;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      dim_log     <= 3'd2;
      pix_cnt     <= '0;
      iv_hold     <= 1'b0;
      r_idx       <= '0;
      c_idx       <= '0;
      k           <= '0;
      ti          <= '0;
      tj          <= '0;
      acc         <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      mac_done    <= 1'b0;
      last_word   <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_value_q <= 1'b0;
    end else begin
      if (!bus.in_valid) iv_hold <= 1'b0;
      unique case (state)
        S_IDLE, S_WAIT: begin
          if (start_calc) begin
            state     <= S_CALC;
            busy_q    <= 1'b1;
            r_idx     <= '0;
            c_idx     <= '0;
            k         <= '0;
            ti        <= '0;
            tj        <= '0;
            acc       <= '0;
            mac_done  <= 1'b0;
            last_word <= 1'b0;
          end else if (start_load) begin
            state   <= S_LOAD;
            busy_q  <= 1'b1;
            dim_log <= dl_nxt;
            pix_cnt <= AW_ONE;
          end
        end
        S_LOAD: begin
          if (!bus.in_valid) begin
            state  <= S_WAIT;
            busy_q <= 1'b0;
          end else if (pix_cnt == pix_last) begin
            // Holding in_valid past the last pixel must not start a reload.
            state   <= S_WAIT;
            busy_q  <= 1'b0;
            iv_hold <= 1'b1;
          end else begin
            pix_cnt <= pix_cnt + AW_ONE;
          end
        end
        S_CALC: begin
          acc <= sum;
          k   <= k + 4'd1;
          ti  <= ti_nx;
          tj  <= tj_nx;
          if (k == 4'd8) begin
            state       <= S_OUT;
            out_valid_q <= 1'b1;
          end
        end
        S_OUT: begin
          if (!mac_done) begin
            acc <= sum;
            if (k == 4'd8) begin
              mac_done <= 1'b1;
            end else begin
              k  <= k + 4'd1;
              ti <= ti_nx;
              tj <= tj_nx;
            end
          end
          if (bit_cnt == BIT_LAST) begin
            if (last_word) begin
              state       <= S_WAIT;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b0;
              out_value_q <= 1'b0;
            end
          end else begin
            out_value_q <= shreg[OUT_W-1];
            shreg       <= shreg << 1;
            bit_cnt     <= bit_cnt + BIT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (load_word) begin
        out_value_q <= word_in[OUT_W-1];
        shreg       <= word_in << 1;
        bit_cnt     <= BIT_ONE;
        acc         <= '0;
        k           <= '0;
        ti          <= '0;
        tj          <= '0;
        if (last_pos) begin
          mac_done  <= 1'b1;
          last_word <= 1'b1;
        end else begin
          mac_done  <= 1'b0;
          r_idx     <= r_nx;
          c_idx     <= c_nx;
        end
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_value = out_value_q;
endmodule

// File: tb/tb_tmip_corr_engine.sv
// Directed bench for tmip_corr_engine: load, trigger, deserialise and compare against hand values
// and a reference correlation.
module tb_tmip_corr_engine;
  localparam int PIX_W   = 8;
  localparam int MAX_DIM = 16;
  localparam int OUT_W   = 2*PIX_W+4;
`ifdef TMIP_CORR_FLIP_EN
  localparam bit FLIP_EN = 1'b1;
`else
  localparam bit FLIP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tmip_corr_engine_if #(.PIX_W(PIX_W)) bus();

  tmip_corr_engine #(.PIX_W(PIX_W), .MAX_DIM(MAX_DIM), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int p_src [256];
  int t_src [9];
  int p_m   [256];
  int t_m   [9];
  int dim_m;
  logic [31:0] res [256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_corr(input int r, input int c, input bit f);
    int s, rr, cc;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        rr = r + i - 1;
        cc = c + j - 1;
        if (rr >= 0 && rr < dim_m && cc >= 0 && cc < dim_m)
          s += t_m[i*3+j] * p_m[rr*dim_m + (f ? dim_m-1-cc : cc)];
      end
    return s;
  endfunction

  task automatic load(input int dim, input logic [1:0] code, input int count);
    dim_m = dim;
    for (int i = 0; i < 256; i++) p_m[i] = (i < count && i < dim*dim) ? p_src[i] : 0;
    for (int i = 0; i < 9; i++)   t_m[i] = (i < count) ? t_src[i] : 0;
    for (int i = 0; i < count; i++) begin
      bus.in_valid   = 1'b1;
      bus.image      = PIX_W'(p_src[i]);
      bus.template   = (i < 9) ? PIX_W'(t_src[i]) : '0;
      bus.image_size = code;
      tick();
      if (i == 0) check_eq("busy_load", bus.busy, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    check_eq("busy_wait", bus.busy, 0);
  endtask

  task automatic run(input bit f, input string tag);
    int n, hi;
    logic [31:0] w;
    bus.in_valid2 = 1'b1;
    bus.flip      = f;
    tick();
    bus.in_valid2 = 1'b0;
    bus.flip      = 1'b0;
    check_eq({tag, "_busy"}, bus.busy, 1);
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq({tag, "_latency"}, n, 9);
    if (!bus.out_valid) return;
    hi = 0;
    for (int p = 0; p < dim_m*dim_m; p++) begin
      w = '0;
      for (int b = 0; b < OUT_W; b++) begin
        if (bus.out_valid) hi++;
        w = {w[30:0], bus.out_value};
        tick();
      end
      res[p] = w;
    end
    check_eq({tag, "_vlen"}, hi, dim_m*dim_m*OUT_W);
    check_eq({tag, "_vdrop"}, bus.out_valid, 0);
    check_eq({tag, "_vzero"}, bus.out_value, 0);
    check_eq({tag, "_bdrop"}, bus.busy, 0);
    for (int p = 0; p < dim_m*dim_m; p++)
      check_eq($sformatf("%s_res%0d", tag, p), res[p], ref_corr(p/dim_m, p%dim_m, f & FLIP_EN));
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      seen |= bus.busy | bus.out_valid;
      tick();
    end
    check_eq(tag, seen, 0);
  endtask

  initial begin
    int n;
    bus.in_valid   = 1'b0;
    bus.image      = '0;
    bus.template   = '0;
    bus.image_size = 2'd0;
    bus.in_valid2  = 1'b0;
    bus.flip       = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_ovalid", bus.out_valid, 0);
    check_eq("rst_ovalue", bus.out_value, 0);
    rst = 1'b0;
    tick();

    // trigger with nothing loaded
    bus.in_valid2 = 1'b1;
    tick();
    bus.in_valid2 = 1'b0;
    idle_watch("noload_trig", 20);

    // 4x4 all ones, in_valid held two cycles past the last pixel
    for (int i = 0; i < 256; i++) p_src[i] = 1;
    for (int i = 0; i < 9; i++)   t_src[i] = 1;
    load(4, 2'd0, 18);
    run(1'b0, "ones");
    check_eq("ones_corner", res[0], 32'h4);
    check_eq("ones_edge", res[1], 6);
    check_eq("ones_inner", res[5], 9);
    check_eq("ones_last", res[15], 4);

    // 8x8 ramp, centre tap only
    for (int i = 0; i < 256; i++) p_src[i] = i % 64;
    for (int i = 0; i < 9; i++)   t_src[i] = (i == 4) ? 1 : 0;
    load(8, 2'd1, 64);
    run(1'b0, "ramp8");
    check_eq("ramp8_r1c1", res[9], 9);
    check_eq("ramp8_last", res[63], 63);

    // 16x16 saturated, then retrigger on the same load
    for (int i = 0; i < 256; i++) p_src[i] = 255;
    for (int i = 0; i < 9; i++)   t_src[i] = 255;
    load(16, 2'd2, 256);
    run(1'b0, "sat16");
    check_eq("sat16_corner", res[0], 260100);
    check_eq("sat16_edge", res[1], 390150);
    check_eq("sat16_inner", res[17], 32'h8EE09);
    run(1'b1, "sat16_rep");
    check_eq("sat16_rep_inner", res[100], 585225);

    // short load: 5 pixels / 5 taps, remainder must read 0
    for (int i = 0; i < 256; i++) p_src[i] = i + 1;
    for (int i = 0; i < 9; i++)   t_src[i] = i + 1;
    load(4, 2'd0, 5);
    run(1'b0, "short");
    check_eq("short_r0c0", res[0], 5);

    // horizontal mirror (mirrored only when the feature is compiled in)
    for (int i = 0; i < 256; i++) p_src[i] = i % 4;
    for (int i = 0; i < 9; i++)   t_src[i] = (i == 4) ? 1 : 0;
    load(4, 2'd0, 16);
    run(1'b1, "flip1");
    for (int c = 0; c < 4; c++)
      check_eq($sformatf("flip1_row_c%0d", c), res[c], FLIP_EN ? 3-c : c);
    run(1'b0, "flip0");
    for (int c = 0; c < 4; c++)
      check_eq($sformatf("flip0_row_c%0d", c), res[c], c);

    // reset in the middle of the stream
    bus.in_valid2 = 1'b1;
    tick();
    bus.in_valid2 = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("midrst_start", bus.out_valid, 1);
    repeat (30) tick();
    rst = 1'b1;
    tick();
    check_eq("midrst_busy", bus.busy, 0);
    check_eq("midrst_ovalid", bus.out_valid, 0);
    check_eq("midrst_ovalue", bus.out_value, 0);
    rst = 1'b0;
    tick();
    bus.in_valid2 = 1'b1;
    tick();
    bus.in_valid2 = 1'b0;
    idle_watch("postrst_trig", 30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
